// File: rtl/decode_queue_pkg.sv
// Shared decode types and MIPS encoding constants for the decode queue.
// DECODE_RI_EXC_EN selects reserved-instruction flagging in decode_lane.
package decode_pkg;

    typedef enum logic [3:0] {
        OC_ALU,
        OC_SHIFT,
        OC_MULDIV,
        OC_LOAD,
        OC_STORE,
        OC_BRANCH,
        OC_JUMP,
        OC_PRIV,
        OC_TRAP,
        OC_CACHE
    } op_class_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic        wr_en;
        logic [4:0]  wr_reg;
        op_class_e   op_class;
        logic        ri;
    } dec_rec_t;

    localparam int DEC_REC_W = $bits(dec_rec_t);

    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LWL      = 6'h22;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_LWR      = 6'h26;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SWL      = 6'h2A;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_SWR      = 6'h2E;
    localparam logic [5:0] OP_CACHE    = 6'h2F;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_SYNC    = 6'h0F;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;
    localparam logic [5:0] FN_MUL     = 6'h02;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0] RS_MF = 5'h00;
    localparam logic [4:0] RS_MT = 5'h04;
    localparam logic [5:0] FN_TLBR  = 6'h01;
    localparam logic [5:0] FN_TLBWI = 6'h02;
    localparam logic [5:0] FN_TLBWR = 6'h06;
    localparam logic [5:0] FN_TLBP  = 6'h08;
    localparam logic [5:0] FN_ERET  = 6'h18;

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        popcnt4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
// master = fetch/issue environment, slave = decode_queue.
interface decode_queue_if #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    localparam int TK_W = $clog2(ISSUE_W + 1);
    localparam int RW   = decode_pkg::DEC_REC_W;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [FETCH_W-1:0]      in_mask;
    logic [FETCH_W*32-1:0]   in_instr;
    logic [FETCH_W*32-1:0]   in_pc;
    logic [ISSUE_W-1:0]      out_valid;
    logic [ISSUE_W*32-1:0]   out_pc;
    logic [ISSUE_W*RW-1:0]   out_rec;
    logic [TK_W-1:0]         out_take;

    modport master (
        output flush, in_valid, in_mask, in_instr, in_pc, out_take,
        input  in_ready, out_valid, out_pc, out_rec
    );

    modport slave (
        input  flush, in_valid, in_mask, in_instr, in_pc, out_take,
        output in_ready, out_valid, out_pc, out_rec
    );

endinterface

// File: rtl/decode_queue_lane.sv
// Combinational single-lane MIPS decoder: raw word in, decoded record out.
// DECODE_RI_EXC_EN flags unsupported encodings as reserved-instruction traps.
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_rec_t    rec_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       known;

    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];
    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];

    always_comb begin
        known          = 1'b1;
        rec_o          = '0;
        rec_o.rs       = rs;
        rec_o.rt       = rt;
        rec_o.rd       = rd;
        rec_o.shamt    = instr_i[10:6];
        rec_o.imm16    = instr_i[15:0];
        rec_o.imm26    = instr_i[25:0];
        rec_o.op_class = OC_ALU;
        unique case (op)
            OP_SPECIAL: begin
                unique case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        rec_o.op_class = OC_SHIFT;
                        rec_o.wr_en    = 1'b1;
                        rec_o.wr_reg   = rd;
                    end
                    FN_JR: rec_o.op_class = OC_JUMP;
                    FN_JALR: begin
                        rec_o.op_class = OC_JUMP;
                        rec_o.wr_en    = 1'b1;
                        rec_o.wr_reg   = rd;
                    end
                    FN_SYSCALL, FN_BREAK: rec_o.op_class = OC_TRAP;
                    FN_SYNC: rec_o.op_class = OC_ALU;
                    FN_MFHI, FN_MFLO: begin
                        rec_o.op_class = OC_MULDIV;
                        rec_o.wr_en    = 1'b1;
                        rec_o.wr_reg   = rd;
                    end
                    FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        rec_o.op_class = OC_MULDIV;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        rec_o.wr_en  = 1'b1;
                        rec_o.wr_reg = rd;
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                rec_o.op_class = OC_BRANCH;
                unique case (rt)
                    RT_BLTZ, RT_BGEZ: ;
                    RT_BLTZAL, RT_BGEZAL: begin
                        rec_o.wr_en  = 1'b1;
                        rec_o.wr_reg = REG_RA;
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_J: rec_o.op_class = OC_JUMP;
            OP_JAL: begin
                rec_o.op_class = OC_JUMP;
                rec_o.wr_en    = 1'b1;
                rec_o.wr_reg   = REG_RA;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: rec_o.op_class = OC_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                rec_o.wr_en  = 1'b1;
                rec_o.wr_reg = rt;
            end
            OP_COP0: begin
                rec_o.op_class = OC_PRIV;
                if (rs == RS_MF) begin
                    rec_o.wr_en  = 1'b1;
                    rec_o.wr_reg = rt;
                end else if (rs == RS_MT) begin
                    known = 1'b1;
                end else if (rs[4] && (fn == FN_TLBR || fn == FN_TLBWI ||
                           fn == FN_TLBWR || fn == FN_TLBP || fn == FN_ERET)) begin
                    known = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
            OP_SPECIAL2: begin
                if (fn == FN_MUL) begin
                    rec_o.op_class = OC_MULDIV;
                    rec_o.wr_en    = 1'b1;
                    rec_o.wr_reg   = rd;
                end else begin
                    known = 1'b0;
                end
            end
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
                rec_o.op_class = OC_LOAD;
                rec_o.wr_en    = 1'b1;
                rec_o.wr_reg   = rt;
            end
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: rec_o.op_class = OC_STORE;
            OP_CACHE: rec_o.op_class = OC_CACHE;
            default: known = 1'b0;
        endcase
        if (!known) begin
            rec_o.wr_en  = 1'b0;
            rec_o.wr_reg = '0;
`ifdef DECODE_RI_EXC_EN
            rec_o.ri       = 1'b1;
            rec_o.op_class = OC_TRAP;
`else
            rec_o.ri       = 1'b0;
            rec_o.op_class = OC_ALU;
`endif
        end
        // The all-zero word encodes sll $0,$0,0 and must never claim a write.
        if (instr_i == 32'h0) begin
            rec_o.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage with a circular instruction buffer in front of issue.
// Build option: DECODE_RI_EXC_EN (reserved-instruction flagging in decode_lane).
module decode_queue
    import decode_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input logic           clk,
    input logic           rst,
    decode_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_W);
    localparam logic [CNT_W-1:0] ISSUE_C = CNT_W'(ISSUE_W);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    dec_rec_t    rec_q [DEPTH];
    logic [31:0] pc_q  [DEPTH];

    dec_rec_t         lane_rec [FETCH_W];
    logic [PTR_W-1:0] wr_idx   [FETCH_W];
    logic [PTR_W-1:0] off;

    logic             enq;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] take_raw;
    logic [CNT_W-1:0] take;

    for (genvar f = 0; f < FETCH_W; f++) begin : g_lane
        decode_lane u_lane (
            .instr_i (q.in_instr[f*32 +: 32]),
            .rec_o   (lane_rec[f])
        );
    end

    assign q.in_ready = (DEPTH_C - count_q) >= FETCH_C;
    assign enq        = q.in_valid && q.in_ready && !q.flush;
    assign n_enq      = enq ? CNT_W'(popcnt4(4'(q.in_mask))) : '0;

    assign vcnt     = (count_q > ISSUE_C) ? ISSUE_C : count_q;
    assign take_raw = CNT_W'(q.out_take);
    assign take     = (take_raw > vcnt) ? vcnt : take_raw;

    // Masked-off lanes leave no hole: each live lane lands after the live lanes before it.
    always_comb begin
        off = '0;
        for (int f = 0; f < FETCH_W; f++) begin
            wr_idx[f] = tail_q + off;
            off       = off + PTR_W'(q.in_mask[f]);
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(take);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + n_enq - take;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int f = 0; f < FETCH_W; f++) begin
                if (q.in_mask[f]) begin
                    rec_q[wr_idx[f]] <= lane_rec[f];
                    pc_q[wr_idx[f]]  <= q.in_pc[f*32 +: 32];
                end
            end
        end
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx                           = head_q + PTR_W'(i);
        assign q.out_valid[i]                   = count_q > CNT_W'(i);
        assign q.out_pc[i*32 +: 32]             = pc_q[rd_idx];
        assign q.out_rec[i*DEC_REC_W +: DEC_REC_W] = rec_q[rd_idx];
    end

    a_take_legal: assert property (
        @(posedge clk) disable iff (rst || q.flush) take_raw <= vcnt
    );

endmodule

// File: tb/tb_decode_queue.sv
// Directed vector bench for decode_queue (FETCH_W=2, ISSUE_W=2, DEPTH=8).
// Expected RI behaviour follows DECODE_RI_EXC_EN when defined for the build.
module tb_decode_queue;
    import decode_pkg::*;

    localparam logic [31:0] ADDU = 32'h00221821;
    localparam logic [31:0] LW   = 32'h8C850000;
    localparam logic [31:0] JAL  = 32'h0C000000;
    localparam logic [31:0] NOP  = 32'h00000000;
    localparam logic [31:0] RIW  = 32'hFC000000;
    localparam logic [31:0] WB   = 32'h0000A000;
`ifdef DECODE_RI_EXC_EN
    localparam logic      RI_EXP = 1'b1;
    localparam logic [3:0] RI_CLS = 4'(OC_TRAP);
`else
    localparam logic      RI_EXP = 1'b0;
    localparam logic [3:0] RI_CLS = 4'(OC_ALU);
`endif

    typedef struct {
        logic        fl;
        logic        v;
        logic [1:0]  m;
        logic [31:0] i0, i1, p0, p1;
        logic [1:0]  tk;
        logic [1:0]  e_vld;
        logic        e_rdy;
        logic [31:0] e_pc0, e_pc1;
        logic        c0, we0, ri0;
        logic [4:0]  wr0;
        logic [3:0]  cl0;
        logic        c1, we1;
        logic [4:0]  wr1;
        logic [3:0]  cl1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    decode_queue_if #(.FETCH_W(2), .ISSUE_W(2)) qif ();

    decode_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif)
    );

    function automatic vec_t mk(
        logic fl, logic v, logic [1:0] m,
        logic [31:0] i0, logic [31:0] i1, logic [31:0] p0, logic [31:0] p1,
        logic [1:0] tk, logic [1:0] evld, logic erdy,
        logic [31:0] epc0, logic [31:0] epc1,
        logic c0 = 0, logic we0 = 0, logic [4:0] wr0 = 0,
        logic [3:0] cl0 = 4'hF, logic ri0 = 0,
        logic c1 = 0, logic we1 = 0, logic [4:0] wr1 = 0,
        logic [3:0] cl1 = 4'hF
    );
        vec_t r;
        r.fl = fl; r.v = v; r.m = m;
        r.i0 = i0; r.i1 = i1; r.p0 = p0; r.p1 = p1; r.tk = tk;
        r.e_vld = evld; r.e_rdy = erdy; r.e_pc0 = epc0; r.e_pc1 = epc1;
        r.c0 = c0; r.we0 = we0; r.wr0 = wr0; r.cl0 = cl0; r.ri0 = ri0;
        r.c1 = c1; r.we1 = we1; r.wr1 = wr1; r.cl1 = cl1;
        return r;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rec(string nm, dec_rec_t r, logic we, logic [4:0] wr,
                           logic [3:0] cl);
        cmp({nm, ".wr_en"}, 32'(r.wr_en), 32'(we));
        if (we) cmp({nm, ".wr_reg"}, 32'(r.wr_reg), 32'(wr));
        if (cl != 4'hF) cmp({nm, ".class"}, 32'(r.op_class), 32'(cl));
    endtask

    task automatic step(vec_t v, string tag);
        dec_rec_t r0, r1;
        qif.flush    = v.fl;
        qif.in_valid = v.v;
        qif.in_mask  = v.m;
        qif.in_instr = {v.i1, v.i0};
        qif.in_pc    = {v.p1, v.p0};
        qif.out_take = v.tk;
        @(posedge clk);
        #1;
        n_vec++;
        r0 = qif.out_rec[DEC_REC_W-1:0];
        r1 = qif.out_rec[2*DEC_REC_W-1:DEC_REC_W];
        cmp({tag, ".vld"}, 32'(qif.out_valid), 32'(v.e_vld));
        cmp({tag, ".rdy"}, 32'(qif.in_ready), 32'(v.e_rdy));
        if (v.e_vld[0]) cmp({tag, ".pc0"}, qif.out_pc[31:0], v.e_pc0);
        if (v.e_vld[1]) cmp({tag, ".pc1"}, qif.out_pc[63:32], v.e_pc1);
        if (v.c0) begin
            chk_rec({tag, ".l0"}, r0, v.we0, v.wr0, v.cl0);
            cmp({tag, ".l0.ri"}, 32'(r0.ri), 32'(v.ri0));
        end
        if (v.c1) chk_rec({tag, ".l1"}, r1, v.we1, v.wr1, v.cl1);
    endtask

    initial begin
        qif.flush    = 1'b0;
        qif.in_valid = 1'b0;
        qif.in_mask  = '0;
        qif.in_instr = '0;
        qif.in_pc    = '0;
        qif.out_take = '0;

        #1;
        n_vec++;
        cmp("reset.vld", 32'(qif.out_valid), 32'd0);
        cmp("reset.rdy", 32'(qif.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        tv.push_back(mk(0,1,2'b11,ADDU,LW,'h100,'h104,0, 2'b11,1,'h100,'h104,
                        1,1,5'd3,4'(OC_ALU),0, 1,1,5'd5,4'(OC_LOAD)));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b00,1,0,0));
        tv.push_back(mk(0,1,2'b11,JAL,NOP,'h200,'h204,0, 2'b11,1,'h200,'h204,
                        1,1,5'd31,4'(OC_JUMP),0, 1,0,5'd0,4'hF));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b00,1,0,0));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h300,'h304,0, 2'b11,1,'h300,'h304));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h308,'h30C,0, 2'b11,1,'h300,'h304));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h310,'h314,0, 2'b11,1,'h300,'h304));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h318,'h31C,0, 2'b11,0,'h300,'h304));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'hDEA0,'hDEA4,1, 2'b11,0,'h304,'h308));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,1, 2'b11,1,'h308,'h30C));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b11,1,'h310,'h314));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b11,1,'h318,'h31C));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b00,1,0,0));
        tv.push_back(mk(0,1,2'b10,NOP,ADDU,'h400,'h404,0, 2'b01,1,'h404,0));
        tv.push_back(mk(0,1,2'b00,ADDU,ADDU,'h4A0,'h4A4,0, 2'b01,1,'h404,0));
        tv.push_back(mk(0,1,2'b01,LW,NOP,'h500,0,1, 2'b01,1,'h500,0,
                        1,1,5'd5,4'(OC_LOAD),0));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h600,'h604,0, 2'b11,1,'h500,'h600));
        tv.push_back(mk(0,1,2'b11,ADDU,ADDU,'h608,'h60C,0, 2'b11,1,'h500,'h600));
        tv.push_back(mk(1,1,2'b11,ADDU,ADDU,'h700,'h704,0, 2'b00,1,0,0));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,0, 2'b00,1,0,0));
        tv.push_back(mk(0,1,2'b11,ADDU,LW,'h800,'h804,0, 2'b11,1,'h800,'h804));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,2, 2'b00,1,0,0));
        tv.push_back(mk(0,1,2'b01,RIW,NOP,'hA00,0,0, 2'b01,1,'hA00,0,
                        1,0,5'd0,RI_CLS,RI_EXP));
        tv.push_back(mk(0,0,2'b00,0,0,0,0,1, 2'b00,1,0,0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i], $sformatf("v%0d", i));
        end

        // Steady stream across the pointer wrap: two in, two out every cycle.
        step(mk(0,1,2'b11,ADDU,ADDU,WB,WB+4,0, 2'b11,1,WB,WB+4), "wrap0");
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] b;
            b = WB + 32'(8 * k);
            step(mk(0,1,2'b11,ADDU,ADDU,b,b+4,2, 2'b11,1,b,b+4),
                 $sformatf("wrap%0d", k));
        end
        step(mk(0,0,2'b00,0,0,0,0,2, 2'b00,1,0,0), "wrap_end");

        // Asynchronous reset in the middle of a cycle with data buffered.
        step(mk(0,1,2'b11,ADDU,ADDU,'hB00,'hB04,0, 2'b11,1,'hB00,'hB04), "rst_pre");
        #2 rst = 1'b1;
        #1;
        n_vec++;
        cmp("rst_mid.vld", 32'(qif.out_valid), 32'd0);
        cmp("rst_mid.rdy", 32'(qif.in_ready), 32'd1);
        qif.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(mk(0,0,2'b00,0,0,0,0,0, 2'b00,1,0,0), "rst_post");
        step(mk(0,1,2'b01,LW,NOP,'hC00,0,0, 2'b01,1,'hC00,0,
                1,1,5'd5,4'(OC_LOAD),0), "rst_enq");
        step(mk(0,0,2'b00,0,0,0,0,1, 2'b00,1,0,0), "rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
